// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared owner encoding and timing constants for the SRAM arbiter.
// Holds the default starvation limit and the fixed SRAM read latency.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // Consecutive data grants tolerated while a fetch waits (fairness build only).
  localparam int STARVE_LIMIT_DEF = 4;

  // Edges from grant to returned data: one access cycle plus one SRAM output cycle.
  localparam int RD_LAT = 2;

endpackage

// File: rtl/arb_tag_pipe.sv
// arb_tag_pipe: 2-stage {valid, owner} shift register steering read returns.
// Latency: stage 0 marks the access cycle, stage 1 the data cycle (RVALID).
// No backpressure: one tag enters per cycle; reset drops all in-flight tags.
module arb_tag_pipe
  import mem_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   in_vld,
  input  owner_t in_own,
  output logic   i_rvalid,
  output logic   d_rvalid
);

  logic   s0_vld;
  owner_t s0_own;
  logic   s1_vld;
  owner_t s1_own;

  // Stage 0: capture the tag of the read accepted on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_vld <= 1'b0;
      s0_own <= OWN_NONE;
    end else begin
      s0_vld <= in_vld;
      s0_own <= in_vld ? in_own : OWN_NONE;
    end
  end

  // Stage 1: advance independently so back-to-back reads overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_own <= OWN_NONE;
    end else begin
      s1_vld <= s0_vld;
      s1_own <= s0_own;
    end
  end

  // Decode the data-cycle tag into per-requester valids.
  always_comb begin
    i_rvalid = s1_vld && (s1_own == OWN_I);
    d_rvalid = s1_vld && (s1_own == OWN_D);
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter in front of one single-port synchronous SRAM.
// Grant is combinational; SRAM signals registered one cycle; read data two cycles after grant.
// Data has fixed priority; with ARB_FAIRNESS_EN a starved fetch wins after STARVE_LIMIT data grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int AW           = 30
)
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          I_REQ,
  input  logic [AW-1:0] I_ADDR,
  output logic          I_GNT,
  output logic          I_RVALID,
  output logic [31:0]   I_RDATA,
  input  logic          D_REQ,
  input  logic          D_RW,
  input  logic [AW-1:0] D_ADDR,
  input  logic [31:0]   D_WDATA,
  output logic          D_GNT,
  output logic          D_RVALID,
  output logic [31:0]   D_RDATA,
  output logic          MEM_CSN,
  output logic          MEM_WEN,
  output logic [AW-1:0] MEM_A,
  output logic [31:0]   MEM_DI,
  input  logic [31:0]   MEM_DOUT
);

  logic   starve;
  logic   i_gnt;
  logic   d_gnt;
  logic   rd_vld;
  owner_t rd_own;

  // Grant: data wins unless the fetch is starved; nothing is granted during reset.
  always_comb begin
    i_gnt = ~RST & I_REQ & (~D_REQ | starve);
    d_gnt = ~RST & D_REQ & ~i_gnt;
  end

  assign I_GNT = i_gnt;
  assign D_GNT = d_gnt;

`ifdef ARB_FAIRNESS_EN
  logic [2:0] starve_cnt;

  assign starve = (starve_cnt == 3'(STARVE_LIMIT));

  // Count consecutive data grants while a fetch waits; saturate at 7.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_cnt <= 3'd0;
    end else if (!I_REQ || i_gnt) begin
      starve_cnt <= 3'd0;
    end else if (d_gnt && (starve_cnt != 3'd7)) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  // Register the SRAM access for the cycle after the transfer edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      MEM_CSN <= 1'b1;
      MEM_WEN <= 1'b1;
      MEM_A   <= '0;
      MEM_DI  <= '0;
    end else if (i_gnt) begin
      MEM_CSN <= 1'b0;
      MEM_WEN <= 1'b1;
      MEM_A   <= I_ADDR;
      MEM_DI  <= '0;
    end else if (d_gnt) begin
      MEM_CSN <= 1'b0;
      MEM_WEN <= ~D_RW;
      MEM_A   <= D_ADDR;
      MEM_DI  <= D_WDATA;
    end else begin
      MEM_CSN <= 1'b1;
      MEM_WEN <= 1'b1;
    end
  end

  // Tag only reads; writes never return data.
  always_comb begin
    rd_vld = i_gnt | (d_gnt & ~D_RW);
    rd_own = i_gnt ? OWN_I : (rd_vld ? OWN_D : OWN_NONE);
  end

  arb_tag_pipe u_tag_pipe (
    .clk      (CLK),
    .rst      (RST),
    .in_vld   (rd_vld),
    .in_own   (rd_own),
    .i_rvalid (I_RVALID),
    .d_rvalid (D_RVALID)
  );

  // Read data is zero unless the owner's return is valid this cycle.
  always_comb begin
    I_RDATA = I_RVALID ? MEM_DOUT : 32'd0;
    D_RDATA = D_RVALID ? MEM_DOUT : 32'd0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus random traffic against a transaction-level model.
// Model predicts grants from priority rules and read data from a reference memory.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW  = 30;
  localparam int LIM = STARVE_LIMIT_DEF;

  logic          CLK = 1'b0;
  logic          RST;
  logic          I_REQ;
  logic [AW-1:0] I_ADDR;
  logic          I_GNT;
  logic          I_RVALID;
  logic [31:0]   I_RDATA;
  logic          D_REQ;
  logic          D_RW;
  logic [AW-1:0] D_ADDR;
  logic [31:0]   D_WDATA;
  logic          D_GNT;
  logic          D_RVALID;
  logic [31:0]   D_RDATA;
  logic          MEM_CSN;
  logic          MEM_WEN;
  logic [AW-1:0] MEM_A;
  logic [31:0]   MEM_DI;
  logic [31:0]   MEM_DOUT = 32'd0;

  mem_arbiter #(.STARVE_LIMIT(LIM), .AW(AW)) dut (
    .CLK(CLK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_RW(D_RW), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_GNT(D_GNT),
    .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
    .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN), .MEM_A(MEM_A), .MEM_DI(MEM_DI), .MEM_DOUT(MEM_DOUT)
  );

  always #5 CLK = ~CLK;

  // Synchronous SRAM device: output valid the cycle after the access cycle.
  logic [31:0] sram    [1024];
  logic [31:0] ref_mem [1024];

  always @(posedge CLK) begin
    if (!MEM_CSN) begin
      if (MEM_WEN) MEM_DOUT <= sram[MEM_A[9:0]];
      else         sram[MEM_A[9:0]] <= MEM_DI;
    end
  end

  typedef struct { bit v; bit wen; logic [AW-1:0] a; logic [31:0] di; } acc_t;
  typedef struct { bit v; bit own_i; logic [31:0] dat; } ret_t;

  acc_t acc_q [4];
  ret_t ret_q [4];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   wait_d = 0;
  bit   fair_en;
  bit   gi;
  bit   gd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin
      acc_q[k] = '{v: 1'b0, wen: 1'b1, a: '0, di: '0};
      ret_q[k] = '{v: 1'b0, own_i: 1'b0, dat: '0};
    end
    wait_d = 0;
  endtask

  // One clock cycle: drive, check this cycle's outputs, advance the model, step the clock.
  task automatic cycle(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit drw,
                       input logic [AW-1:0] da, input logic [31:0] dw,
                       output bit obs_i, output bit obs_d);
    bit   exp_i;
    bit   exp_d;
    int   slot;
    acc_t ea;
    ret_t er;
    I_REQ = ir; I_ADDR = ia; D_REQ = dr; D_RW = drw; D_ADDR = da; D_WDATA = dw;
    #1;
    exp_i = ir && (!dr || (fair_en && wait_d == LIM));
    exp_d = dr && !exp_i;
    chk("i_gnt", I_GNT, exp_i);
    chk("d_gnt", D_GNT, exp_d);
    slot = cyc % 4;
    ea = acc_q[slot];
    er = ret_q[slot];
    chk("mem_csn", MEM_CSN, !ea.v);
    chk("mem_wen", MEM_WEN, ea.v ? ea.wen : 1'b1);
    if (ea.v) chk("mem_a", MEM_A, ea.a);
    if (ea.v && !ea.wen) chk("mem_di", MEM_DI, ea.di);
    chk("i_rvalid", I_RVALID, er.v && er.own_i);
    chk("d_rvalid", D_RVALID, er.v && !er.own_i);
    chk("i_rdata", I_RDATA, (er.v && er.own_i) ? er.dat : 32'd0);
    chk("d_rdata", D_RDATA, (er.v && !er.own_i) ? er.dat : 32'd0);
    obs_i = I_GNT;
    obs_d = D_GNT;
    if (exp_i) begin
      acc_q[(cyc + 1) % 4] = '{v: 1'b1, wen: 1'b1, a: ia, di: '0};
      ret_q[(cyc + RD_LAT) % 4] = '{v: 1'b1, own_i: 1'b1, dat: ref_mem[ia[9:0]]};
    end else if (exp_d) begin
      acc_q[(cyc + 1) % 4] = '{v: 1'b1, wen: !drw, a: da, di: dw};
      if (drw) ref_mem[da[9:0]] = dw;
      else ret_q[(cyc + RD_LAT) % 4] = '{v: 1'b1, own_i: 1'b0, dat: ref_mem[da[9:0]]};
    end
    if (!ir || exp_i) wait_d = 0;
    else if (exp_d && wait_d < 7) wait_d++;
    acc_q[slot] = '{v: 1'b0, wen: 1'b1, a: '0, di: '0};
    ret_q[slot] = '{v: 1'b0, own_i: 1'b0, dat: '0};
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_csn"}, MEM_CSN, 1'b1);
    chk({tag, "_wen"}, MEM_WEN, 1'b1);
    chk({tag, "_a"}, MEM_A, '0);
    chk({tag, "_di"}, MEM_DI, 32'd0);
    chk({tag, "_rvalid"}, {I_RVALID, D_RVALID}, 2'b00);
    chk({tag, "_rdata"}, {I_RDATA, D_RDATA}, 64'd0);
    chk({tag, "_gnt"}, {I_GNT, D_GNT}, 2'b00);
  endtask

  // Reset with both requests high to show grants are suppressed.
  task automatic do_reset();
    I_REQ = 1'b1; D_REQ = 1'b1; D_RW = 1'b0;
    RST = 1'b1;
    #1;
    chk_reset_outputs("rst_a");
    @(posedge CLK);
    #1;
    chk_reset_outputs("rst_b");
    clear_model();
    I_REQ = 1'b0; D_REQ = 1'b0;
    RST = 1'b0;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, '0, 1'b0, 1'b0, '0, 32'd0, gi, gd);
  endtask

  initial begin
`ifdef ARB_FAIRNESS_EN
    fair_en = 1'b1;
`else
    fair_en = 1'b0;
`endif
    for (int k = 0; k < 1024; k++) begin
      sram[k]    = $urandom;
      ref_mem[k] = sram[k];
    end
    sram[16'h10]    = 32'hDEADBEEF;
    ref_mem[16'h10] = 32'hDEADBEEF;
    I_REQ = 1'b0; I_ADDR = '0; D_REQ = 1'b0; D_RW = 1'b0; D_ADDR = '0; D_WDATA = '0;
    clear_model();
    do_reset();

    // Lone fetch right after reset release: grant same cycle, data 0xDEADBEEF two later.
    cycle(1'b1, 30'h10, 1'b0, 1'b0, '0, 32'd0, gi, gd);
    chk("fetch_gnt", gi, 1'b1);
    chk("fetch_acc_a", {MEM_CSN, MEM_A}, {1'b0, 30'h10});
    idle(1);
    chk("fetch_rdata", {I_RVALID, I_RDATA}, {1'b1, 32'hDEADBEEF});
    idle(2);

    // Both request: data read first, fetch next cycle, returns in consecutive cycles.
    cycle(1'b1, 30'h30, 1'b1, 1'b0, 30'h20, 32'd0, gi, gd);
    chk("both_gnt", {gi, gd}, 2'b01);
    cycle(1'b1, 30'h30, 1'b0, 1'b0, '0, 32'd0, gi, gd);
    chk("both_next_gnt", {gi, gd}, 2'b10);
    idle(3);

    // Data write then read back through the SRAM.
    cycle(1'b0, '0, 1'b1, 1'b1, 30'h8, 32'h55, gi, gd);
    chk("wr_access", {MEM_CSN, MEM_WEN, MEM_DI}, {1'b0, 1'b0, 32'h55});
    idle(3);
    cycle(1'b0, '0, 1'b1, 1'b0, 30'h8, 32'd0, gi, gd);
    idle(3);

    // Both held high for ten cycles: grant pattern depends on the fairness build.
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 30'($urandom_range(0, 1023)), 1'b1, 1'b0, 30'($urandom_range(0, 1023)),
            32'd0, gi, gd);
      chk("fair_pattern", gi, fair_en && (k % 5 == 4));
    end
    idle(3);

    // Reset one cycle after a read grant: the read must never return.
    cycle(1'b1, 30'h10, 1'b0, 1'b0, '0, 32'd0, gi, gd);
    do_reset();
    idle(1);
    chk("rst_drop_rvalid", {I_RVALID, D_RVALID}, 2'b00);
    idle(2);

    // Eight alternating back-to-back reads: continuous access, returns in order.
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) cycle(1'b1, 30'($urandom_range(0, 1023)), 1'b0, 1'b0, '0, 32'd0, gi, gd);
      else cycle(1'b0, '0, 1'b1, 1'b0, 30'($urandom_range(0, 1023)), 32'd0, gi, gd);
    end
    idle(3);

    // Random mixed traffic.
    for (int k = 0; k < 80; k++) begin
      cycle(1'($urandom_range(0, 1)), 30'($urandom_range(0, 1023)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            30'($urandom_range(0, 1023)), $urandom, gi, gd);
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
